// File: rtl/game_pkg.sv
// Shared types and defaults for the runner game core.
//   game_state_t : top-level game flow (start screen, running game, game over)
//   action_t     : dragon animation selector consumed by the renderer
//   DEF_KEY_*    : default keycodes from the keyboard decoder
//   sat_inc16    : saturating 16-bit increment used by the score counter
package game_pkg;

  typedef enum logic [1:0] {
    GsStart = 2'd0,
    GsGame  = 2'd1,
    GsOver  = 2'd2
  } game_state_t;

  typedef enum logic [2:0] {
    ActRest = 3'd0,
    ActRun  = 3'd1,
    ActJump = 3'd2,
    ActDuck = 3'd3,
    ActDead = 3'd4
  } action_t;

  localparam logic [7:0] DEF_KEY_JUMP  = 8'h20;
  localparam logic [7:0] DEF_KEY_DUCK  = 8'h26;
  localparam logic [7:0] DEF_KEY_START = 8'h0D;

  // Screen coordinates and obstacle fields are all this wide.
  localparam int unsigned COORD_W = 10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/runner_hit_detect.sv
// Combinational box-overlap test between the dragon and one obstacle lane.
// Ports:
//   obs_valid : lane holds an obstacle
//   obs_x     : obstacle left edge
//   obs_w     : obstacle width
//   obs_h     : obstacle height; obstacle occupies Y [GROUND-obs_h, GROUND)
//   bottom    : dragon bottom Y (box occupies Y [bottom-height, bottom))
//   height    : dragon box height
//   hit       : lane is valid and both X and Y ranges overlap
module runner_hit_detect
  import game_pkg::*;
#(
  parameter int unsigned GROUND   = 400,
  parameter int unsigned DRAGON_X = 80,
  parameter int unsigned DRAGON_W = 20
) (
  input  logic               obs_valid,
  input  logic [COORD_W-1:0] obs_x,
  input  logic [COORD_W-1:0] obs_w,
  input  logic [COORD_W-1:0] obs_h,
  input  logic [COORD_W-1:0] bottom,
  input  logic [COORD_W-1:0] height,
  output logic               hit
);

  localparam int unsigned W = COORD_W + 1;

  logic [W-1:0] obs_left;
  logic [W-1:0] obs_right;
  logic [W-1:0] obs_bot_reach;
  logic [W-1:0] dragon_top_reach;
  logic         x_overlap;
  logic         y_overlap;

  assign obs_left  = {1'b0, obs_x};
  assign obs_right = {1'b0, obs_x} + {1'b0, obs_w};

  // Both Y terms are rearranged so nothing is subtracted: GROUND-obs_h < bottom becomes
  // GROUND < bottom+obs_h, and GROUND > bottom-height becomes GROUND+height > bottom.
  assign obs_bot_reach    = {1'b0, bottom} + {1'b0, obs_h};
  assign dragon_top_reach = W'(GROUND) + {1'b0, height};

  assign x_overlap = (obs_left < W'(DRAGON_X + DRAGON_W)) && (obs_right > W'(DRAGON_X));
  assign y_overlap = (W'(GROUND) < obs_bot_reach) && (dragon_top_reach > {1'b0, bottom});

  assign hit = obs_valid && x_overlap && y_overlap;

endmodule

// File: rtl/runner_core.sv
// Per-frame game core for the runner game.
// Holds the start/game/over flow, dragon vertical physics (variable-height jump with a
// one-time hold boost, duck, fast-fall), obstacle collision, lives, invulnerability and score.
// Ports:
//   frame_clk     : frame clock, all state updates on its rising edge
//   Reset_n       : synchronous active-low reset
//   keycode       : current key from the keyboard decoder (8'h00 = none)
//   Obs_Valid     : per-lane obstacle present
//   Obs_X/W/H     : per-lane obstacle left edge / width / height, lane i at [10*i +: 10]
//   Game_State    : game_state_t
//   Action        : action_t
//   Dragon_Bottom : dragon bottom Y (screen Y grows downward)
//   Dragon_H      : current dragon box height
//   Lives         : remaining lives
//   Score         : GAME frames survived, saturating
//   Hit           : one-frame pulse when a life is lost
//   Dead          : high while in the game-over state
// All outputs are registered and reflect the inputs of the previous frame.
module runner_core
  import game_pkg::*;
#(
  parameter int unsigned NUM_OBS   = 3,
  parameter int unsigned GROUND    = 400,
  parameter int unsigned DRAGON_X  = 80,
  parameter int unsigned DRAGON_W  = 20,
  parameter int unsigned STAND_H   = 40,
  parameter int unsigned DUCK_H    = 24,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned JUMP_V    = 10,
  parameter int unsigned BOOST_V   = 5,
  parameter int unsigned HOLD_CYC  = 8,
  parameter int unsigned MAX_FALL  = 15,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned INVULN    = 30,
  parameter logic [7:0]  KEY_JUMP  = DEF_KEY_JUMP,
  parameter logic [7:0]  KEY_DUCK  = DEF_KEY_DUCK,
  parameter logic [7:0]  KEY_START = DEF_KEY_START
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic [7:0]           keycode,
  input  logic [NUM_OBS-1:0]   Obs_Valid,
  input  logic [NUM_OBS*10-1:0] Obs_X,
  input  logic [NUM_OBS*10-1:0] Obs_W,
  input  logic [NUM_OBS*10-1:0] Obs_H,
  output logic [1:0]           Game_State,
  output logic [2:0]           Action,
  output logic [9:0]           Dragon_Bottom,
  output logic [9:0]           Dragon_H,
  output logic [2:0]           Lives,
  output logic [15:0]          Score,
  output logic                 Hit,
  output logic                 Dead
);

  localparam logic [1:0] ST_START = GsStart;
  localparam logic [1:0] ST_GAME  = GsGame;
  localparam logic [1:0] ST_OVER  = GsOver;

  localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);
  localparam int unsigned InvW  = $clog2(INVULN + 1);

  // State registers
  logic [1:0]              state_q, state_d;
  logic [9:0]              bottom_q, bottom_d;
  logic signed [9:0]       v_q, v_d;
  logic [2:0]              lives_q, lives_d;
  logic [15:0]             score_q, score_d;
  logic                    hit_q, hit_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic                    boosted_q, boosted_d;
  logic [InvW-1:0]         invuln_q, invuln_d;
  logic [7:0]              key_q;
  logic [9:0]              dragon_h_q, dragon_h_d;
  logic [2:0]              action_q, action_d;
  logic                    dead_q, dead_d;

  // Decoded keys
  logic key_start;
  logic jump_held;
  logic duck_held;
  logic jump_edge;

  assign key_start = (keycode == KEY_START);
  assign jump_held = (keycode == KEY_JUMP);
  assign duck_held = (keycode == KEY_DUCK);
  assign jump_edge = jump_held && (key_q != KEY_JUMP);

  // Collision: one AABB test per lane against the currently displayed dragon box.
  logic [NUM_OBS-1:0] lane_hit;
  logic               any_hit;

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_lane
    runner_hit_detect #(
      .GROUND   (GROUND),
      .DRAGON_X (DRAGON_X),
      .DRAGON_W (DRAGON_W)
    ) u_hit (
      .obs_valid (Obs_Valid[i]),
      .obs_x     (Obs_X[10*i +: 10]),
      .obs_w     (Obs_W[10*i +: 10]),
      .obs_h     (Obs_H[10*i +: 10]),
      .bottom    (bottom_q),
      .height    (dragon_h_q),
      .hit       (lane_hit[i])
    );
  end

  assign any_hit = |lane_hit;

  // Physics helpers, evaluated in 12-bit signed so position and velocity sums cannot wrap.
  logic               on_ground;
  logic signed [11:0] pos_sum;
  logic signed [11:0] v_sum;
  logic [11:0]        grav;
  logic signed [9:0]  v_fall;
  logic               ground_d;

  assign on_ground = (bottom_q == 10'(GROUND)) && (v_q == '0);
  assign pos_sum   = $signed({2'b00, bottom_q}) + $signed({{2{v_q[9]}}, v_q});
  assign grav      = duck_held ? 12'(2 * GRAVITY) : 12'(GRAVITY);
  assign v_sum     = $signed({{2{v_q[9]}}, v_q}) + $signed(grav);
  assign v_fall    = (v_sum > $signed(12'(MAX_FALL))) ? 10'(MAX_FALL) : v_sum[9:0];

  always_comb begin
    state_d   = state_q;
    bottom_d  = bottom_q;
    v_d       = v_q;
    lives_d   = lives_q;
    score_d   = score_q;
    hit_d     = 1'b0;
    hold_d    = hold_q;
    boosted_d = boosted_q;
    invuln_d  = invuln_q;

    if (key_start) begin
      // Start key wins over everything: full reinit regardless of state.
      state_d   = ST_START;
      bottom_d  = 10'(GROUND);
      v_d       = '0;
      lives_d   = 3'(LIVES);
      score_d   = '0;
      hold_d    = '0;
      boosted_d = 1'b0;
      invuln_d  = '0;
    end else begin
      unique case (state_q)
        ST_START: begin
          // The starting jump edge only launches the game; no impulse this frame.
          if (jump_edge) state_d = ST_GAME;
        end

        ST_GAME: begin
          score_d = sat_inc16(score_q);

          if (on_ground) begin
            if (jump_edge) begin
              v_d       = 10'(0) - 10'(JUMP_V);
              hold_d    = HoldW'(1);
              boosted_d = 1'b0;
            end else begin
              hold_d = '0;
            end
          end else if (pos_sum >= $signed(12'(GROUND))) begin
            bottom_d  = 10'(GROUND);
            v_d       = '0;
            hold_d    = '0;
            boosted_d = 1'b0;
          end else begin
            bottom_d = pos_sum[9:0];
            v_d      = v_fall;
            if (!jump_held) begin
              hold_d = '0;
            end else if (v_q[9] && !boosted_q && (hold_q < HoldW'(HOLD_CYC))) begin
              hold_d = hold_q + HoldW'(1);
              // Boost is applied on top of this frame's gravity step, once per jump.
              if (hold_q + HoldW'(1) == HoldW'(HOLD_CYC)) begin
                v_d       = v_fall - 10'(BOOST_V);
                boosted_d = 1'b1;
              end
            end
          end

          if (invuln_q != '0) begin
            invuln_d = invuln_q - InvW'(1);
          end else if (any_hit) begin
            lives_d  = lives_q - 3'd1;
            hit_d    = 1'b1;
            invuln_d = InvW'(INVULN);
            if (lives_q == 3'd1) state_d = ST_OVER;
          end
        end

        ST_OVER: begin
          // Everything frozen until the start key.
        end

        default: state_d = ST_START;
      endcase
    end
  end

  // Display-facing outputs derived from the next state so they line up with it.
  always_comb begin
    ground_d   = (bottom_d == 10'(GROUND)) && (v_d == '0);
    dead_d     = (state_d == ST_OVER);
    dragon_h_d = 10'(STAND_H);
    action_d   = ActRest;
    if ((state_d == ST_GAME) && ground_d && duck_held) dragon_h_d = 10'(DUCK_H);
    unique case (state_d)
      ST_START: action_d = ActRest;
      ST_OVER:  action_d = ActDead;
      ST_GAME: begin
        if (!ground_d)     action_d = ActJump;
        else if (duck_held) action_d = ActDuck;
        else               action_d = ActRun;
      end
      default:  action_d = ActRest;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q    <= ST_START;
      bottom_q   <= 10'(GROUND);
      v_q        <= '0;
      lives_q    <= 3'(LIVES);
      score_q    <= '0;
      hit_q      <= 1'b0;
      hold_q     <= '0;
      boosted_q  <= 1'b0;
      invuln_q   <= '0;
      key_q      <= 8'h00;
      dragon_h_q <= 10'(STAND_H);
      action_q   <= ActRest;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bottom_q   <= bottom_d;
      v_q        <= v_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      hold_q     <= hold_d;
      boosted_q  <= boosted_d;
      invuln_q   <= invuln_d;
      key_q      <= keycode;
      dragon_h_q <= dragon_h_d;
      action_q   <= action_d;
      dead_q     <= dead_d;
    end
  end

  assign Game_State    = state_q;
  assign Action        = action_q;
  assign Dragon_Bottom = bottom_q;
  assign Dragon_H      = dragon_h_q;
  assign Lives         = lives_q;
  assign Score         = score_q;
  assign Hit           = hit_q;
  assign Dead          = dead_q;

endmodule

// File: tb/tb_runner_core.sv
module tb_runner_core;

  localparam logic [7:0] KJ = 8'h20;
  localparam logic [7:0] KD = 8'h26;
  localparam logic [7:0] KS = 8'h0D;

  logic        frame_clk = 1'b0;
  logic        Reset_n   = 1'b0;
  logic [7:0]  keycode   = 8'h00;
  logic [2:0]  Obs_Valid = '0;
  logic [29:0] Obs_X     = '0;
  logic [29:0] Obs_W     = '0;
  logic [29:0] Obs_H     = '0;
  logic [1:0]  Game_State;
  logic [2:0]  Action;
  logic [9:0]  Dragon_Bottom;
  logic [9:0]  Dragon_H;
  logic [2:0]  Lives;
  logic [15:0] Score;
  logic        Hit;
  logic        Dead;

  int checks = 0;
  int passes = 0;

  // Reference model: plain integers, states 0=START 1=GAME 2=OVER,
  // actions 0=REST 1=RUN 2=JUMP 3=DUCK 4=DEAD.
  int m_state, m_bottom, m_v, m_lives, m_score, m_hit, m_inv, m_hold, m_boost;
  int m_h, m_act, m_dead;
  logic [7:0] m_prev;

  runner_core dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .keycode       (keycode),
    .Obs_Valid     (Obs_Valid),
    .Obs_X         (Obs_X),
    .Obs_W         (Obs_W),
    .Obs_H         (Obs_H),
    .Game_State    (Game_State),
    .Action        (Action),
    .Dragon_Bottom (Dragon_Bottom),
    .Dragon_H      (Dragon_H),
    .Lives         (Lives),
    .Score         (Score),
    .Hit           (Hit),
    .Dead          (Dead)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic model_init();
    m_state = 0; m_bottom = 400; m_v = 0; m_lives = 3; m_score = 0; m_hit = 0;
    m_inv = 0; m_hold = 0; m_boost = 0; m_h = 40; m_act = 0; m_dead = 0;
  endtask

  task automatic model_step(input logic [7:0] key);
    bit edge_j;
    bit grounded;
    int hits;
    edge_j   = (key == KJ) && (m_prev != KJ);
    grounded = (m_bottom == 400) && (m_v == 0);
    m_hit    = 0;
    if (key == KS) begin
      model_init();
    end else if (m_state == 0) begin
      if (edge_j) m_state = 1;
    end else if (m_state == 1) begin
      hits = 0;
      for (int i = 0; i < 3; i++) begin
        int ox, ow, oh;
        ox = int'(Obs_X[10*i +: 10]);
        ow = int'(Obs_W[10*i +: 10]);
        oh = int'(Obs_H[10*i +: 10]);
        if (Obs_Valid[i] && ox < 100 && ox + ow > 80 && 400 - oh < m_bottom &&
            400 > m_bottom - m_h)
          hits++;
      end
      m_score = (m_score < 65535) ? m_score + 1 : 65535;
      if (grounded) begin
        if (edge_j) begin
          m_v = -10; m_hold = 1; m_boost = 0;
        end else begin
          m_hold = 0;
        end
      end else if (m_bottom + m_v >= 400) begin
        m_bottom = 400; m_v = 0; m_hold = 0; m_boost = 0;
      end else begin
        int nv;
        int old_v;
        old_v    = m_v;
        m_bottom = m_bottom + m_v;
        nv       = old_v + ((key == KD) ? 2 : 1);
        if (nv > 15) nv = 15;
        if (key != KJ) begin
          m_hold = 0;
        end else if (old_v < 0 && m_boost == 0 && m_hold < 8) begin
          m_hold++;
          if (m_hold == 8) begin
            nv = nv - 5; m_boost = 1;
          end
        end
        m_v = nv;
      end
      if (m_inv > 0) begin
        m_inv--;
      end else if (hits > 0) begin
        m_lives--; m_hit = 1; m_inv = 30;
        if (m_lives == 0) m_state = 2;
      end
    end
    m_prev = key;
    grounded = (m_bottom == 400) && (m_v == 0);
    m_h    = (m_state == 1 && grounded && key == KD) ? 24 : 40;
    m_dead = (m_state == 2) ? 1 : 0;
    if (m_state == 0)      m_act = 0;
    else if (m_state == 2) m_act = 4;
    else if (!grounded)    m_act = 2;
    else if (key == KD)    m_act = 3;
    else                   m_act = 1;
  endtask

  task automatic tick(input logic [7:0] key);
    keycode = key;
    @(posedge frame_clk);
    model_step(key);
    #1;
  endtask

  task automatic set_lane(input int i, input bit v, input int x, input int w, input int h);
    Obs_Valid[i]      = v;
    Obs_X[10*i +: 10] = 10'(x);
    Obs_W[10*i +: 10] = 10'(w);
    Obs_H[10*i +: 10] = 10'(h);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    keycode = 8'h00;
    repeat (2) begin
      @(posedge frame_clk);
      model_init();
      m_prev = 8'h00;
      #1;
    end
    Reset_n = 1'b1;
    checks++; if (Game_State !== 2'd0) $display("FAIL reset_state got %0d want 0", Game_State); else passes++;
    checks++; if (Dragon_Bottom !== 10'd400) $display("FAIL reset_bottom got %0d want 400", Dragon_Bottom); else passes++;
    checks++; if (Lives !== 3'd3) $display("FAIL reset_lives got %0d want 3", Lives); else passes++;
    checks++; if (Score !== 16'd0) $display("FAIL reset_score got %0d want 0", Score); else passes++;
    checks++; if (Action !== 3'd0) $display("FAIL reset_action got %0d want 0", Action); else passes++;
    checks++; if ({Hit, Dead} !== 2'b00) $display("FAIL reset_hit_dead got %b want 00", {Hit, Dead}); else passes++;
    checks++; if (Dragon_H !== 10'd40) $display("FAIL reset_height got %0d want 40", Dragon_H); else passes++;
    tick(8'h00);
    checks++; if (Game_State !== 2'd0) $display("FAIL idle_start got %0d want 0", Game_State); else passes++;
  endtask

  task automatic test_start();
    tick(KJ);
    checks++; if (Game_State !== 2'd1) $display("FAIL start_to_game got %0d want 1", Game_State); else passes++;
    checks++; if (Dragon_Bottom !== 10'd400) $display("FAIL start_no_impulse got %0d want 400", Dragon_Bottom); else passes++;
    checks++; if (Action !== 3'd1) $display("FAIL start_action got %0d want 1", Action); else passes++;
    tick(8'h00);
    checks++; if (Score !== 16'd1) $display("FAIL first_score got %0d want 1", Score); else passes++;
  endtask

  task automatic test_short_jump();
    tick(KJ);
    checks++; if ({Action, Dragon_Bottom} !== {3'd2, 10'd400})
      $display("FAIL jump_edge got act %0d bottom %0d want act 2 bottom 400", Action, Dragon_Bottom);
    else passes++;
    repeat (10) tick(8'h00);
    checks++; if (Dragon_Bottom !== 10'd345) $display("FAIL short_apex got %0d want 345", Dragon_Bottom); else passes++;
    repeat (10) tick(8'h00);
    checks++; if (Dragon_Bottom !== 10'd390) $display("FAIL short_descent got %0d want 390", Dragon_Bottom); else passes++;
    tick(8'h00);
    checks++; if ({Action, Dragon_Bottom} !== {3'd1, 10'd400})
      $display("FAIL short_land got act %0d bottom %0d want act 1 bottom 400", Action, Dragon_Bottom);
    else passes++;
  endtask

  task automatic test_long_jump();
    int min_b;
    bit landed;
    min_b = 1023;
    for (int f = 0; f < 20; f++) begin
      tick(KJ);
      if (int'(Dragon_Bottom) < min_b) min_b = int'(Dragon_Bottom);
      checks++; if (Dragon_Bottom !== 10'(m_bottom))
        $display("FAIL long_traj frame %0d got %0d want %0d", f, Dragon_Bottom, m_bottom);
      else passes++;
    end
    checks++; if (!(min_b < 345)) $display("FAIL long_apex got %0d want below 345", min_b); else passes++;
    tick(8'h00);
    tick(KJ);
    checks++; if ({Action, Dragon_Bottom} !== {3'd2, 10'(m_bottom)})
      $display("FAIL air_edge got act %0d bottom %0d want act 2 bottom %0d", Action, Dragon_Bottom, m_bottom);
    else passes++;
    landed = 1'b0;
    for (int f = 0; f < 60 && !landed; f++) begin
      tick(8'h00);
      if (Dragon_Bottom == 10'd400 && Action == 3'd1) landed = 1'b1;
    end
    checks++; if (!landed) $display("FAIL long_land got bottom %0d want 400 within 60 frames", Dragon_Bottom); else passes++;
  endtask

  task automatic test_hit_invuln();
    int extra;
    tick(KS);
    checks++; if ({Game_State, Lives, Score} !== {2'd0, 3'd3, 16'd0})
      $display("FAIL restart got st %0d lives %0d score %0d want 0 3 0", Game_State, Lives, Score);
    else passes++;
    tick(KJ);
    tick(8'h00);
    set_lane(0, 1'b1, 90, 10, 30);
    tick(8'h00);
    checks++; if ({Hit, Lives} !== {1'b1, 3'd2})
      $display("FAIL first_hit got hit %0d lives %0d want 1 2", Hit, Lives);
    else passes++;
    extra = 0;
    repeat (30) begin
      tick(8'h00);
      if (Hit) extra++;
    end
    checks++; if (extra != 0 || Lives !== 3'd2)
      $display("FAIL invuln got %0d hits lives %0d want 0 hits lives 2", extra, Lives);
    else passes++;
    tick(8'h00);
    checks++; if ({Hit, Lives} !== {1'b1, 3'd1})
      $display("FAIL second_hit got hit %0d lives %0d want 1 1", Hit, Lives);
    else passes++;
    tick(8'h00);
    checks++; if (Hit !== 1'b0) $display("FAIL hit_pulse got %0d want 0", Hit); else passes++;
    set_lane(0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_multi_lane_over();
    repeat (30) tick(8'h00);
    // Touching edges only and an invalid overlapping lane: no hit.
    set_lane(0, 1'b1, 100, 10, 30);
    set_lane(1, 1'b1, 60, 20, 30);
    set_lane(2, 1'b0, 85, 10, 30);
    tick(8'h00);
    checks++; if ({Hit, Lives} !== {1'b0, 3'd1})
      $display("FAIL edge_no_hit got hit %0d lives %0d want 0 1", Hit, Lives);
    else passes++;
    set_lane(0, 1'b1, 90, 10, 30);
    set_lane(1, 1'b1, 70, 20, 50);
    tick(8'h00);
    checks++; if ({Hit, Lives} !== {1'b1, 3'd0})
      $display("FAIL multi_hit got hit %0d lives %0d want 1 0", Hit, Lives);
    else passes++;
    tick(KJ);
    checks++; if ({Dead, Game_State, Action} !== {1'b1, 2'd2, 3'd4})
      $display("FAIL over got dead %0d st %0d act %0d want 1 2 4", Dead, Game_State, Action);
    else passes++;
    repeat (5) tick(8'h00);
    checks++; if (Score !== 16'(m_score) || Dragon_Bottom !== 10'd400)
      $display("FAIL frozen got score %0d bottom %0d want %0d 400", Score, Dragon_Bottom, m_score);
    else passes++;
    tick(KS);
    checks++; if ({Game_State, Lives, Score, Dead} !== {2'd0, 3'd3, 16'd0, 1'b0})
      $display("FAIL over_restart got st %0d lives %0d score %0d dead %0d want 0 3 0 0",
               Game_State, Lives, Score, Dead);
    else passes++;
    Obs_Valid = '0;
  endtask

  task automatic test_random();
    logic [7:0] key;
    logic [45:0] got, exp;
    int bad;
    key = 8'h00;
    bad = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 35)      key = KJ;
        else if (r < 55) key = KD;
        else if (r < 57) key = KS;
        else if (r < 62) key = 8'h41;
        else             key = 8'h00;
      end
      for (int i = 0; i < 3; i++)
        set_lane(i, ($urandom_range(0, 9) == 0), $urandom_range(40, 140),
                 $urandom_range(1, 30), $urandom_range(1, 100));
      tick(key);
      got = {Game_State, Action, Dragon_Bottom, Dragon_H, Lives, Score, Hit, Dead};
      exp = {2'(m_state), 3'(m_act), 10'(m_bottom), 10'(m_h), 3'(m_lives), 16'(m_score),
             1'(m_hit), 1'(m_dead)};
      checks++;
      if (got !== exp) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d got st%0d act%0d bot%0d h%0d lv%0d sc%0d hit%0d dead%0d want st%0d act%0d bot%0d h%0d lv%0d sc%0d hit%0d dead%0d",
                   c, Game_State, Action, Dragon_Bottom, Dragon_H, Lives, Score, Hit, Dead,
                   m_state, m_act, m_bottom, m_h, m_lives, m_score, m_hit, m_dead);
      end else begin
        passes++;
      end
    end
  endtask

  initial begin
    model_init();
    m_prev = 8'h00;
    test_reset();
    test_start();
    test_short_jump();
    test_long_jump();
    test_hit_invuln();
    test_multi_lane_over();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
